// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Single owner of the SDRAM byte port. Shares it between ioctl download writes,
// CPU reads/writes and tape reads (tape only inside Z80 refresh windows) using
// fixed priority and one outstanding access at a time. Also produces cpu_wait.
module sram_port_arbiter #(
   parameter int AW      = 25,
   parameter int TIMEOUT = 63,
   parameter int TCACHE  = 1
) (
   input  logic          clk,
   input  logic          reset,
   // ioctl download
   input  logic          ioctl_wr,
   input  logic [AW-1:0] ioctl_addr,
   input  logic [7:0]    ioctl_data,
   output logic          ioctl_ovf,
   // CPU
   input  logic          cpu_rd,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_wait,
   // tape
   input  logic          rfsh_n,
   input  logic          tape_rd,
   input  logic [AW-1:0] tape_addr,
   output logic [7:0]    tape_data,
   output logic          tape_valid,
   // sram core
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   input  logic          mem_ack,
   input  logic [7:0]    mem_dout
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IOC, OWN_CPU, OWN_TAPE} owner_t;

   state_t         state, state_nxt;
   owner_t         owner;
   logic [CW-1:0]  tmo_cnt;

   logic           gnt_ioc, gnt_cpu, gnt_tape;
   logic           done_ack, done_abort, done;
   logic [7:0]     rdata;

   // ioctl one-entry buffer
   logic           ioc_full;
   logic [AW-1:0]  ioc_addr;
   logic [7:0]     ioc_data;

   // CPU request latch
   logic           cpu_prev, cpu_act, cpu_rise, cpu_pend;
   logic           cpu_we_q;
   logic [AW-1:0]  cpu_addr_q;
   logic [7:0]     cpu_din_q;

   // tape request latch and one-address cache
   logic           rfsh_prev, tape_fall, tape_pend, tape_hit;
   logic [AW-1:0]  tape_addr_q;
   logic           cache_vld;
   logic [AW-1:0]  cache_addr;

   assign cpu_act   = cpu_rd | cpu_we;
   assign cpu_rise  = cpu_act & ~cpu_prev;
   assign tape_fall = rfsh_prev & ~rfsh_n;
   assign tape_hit  = (TCACHE != 0) && cache_vld && (tape_addr == cache_addr);

   // request pulse comes straight off the state so an async reset kills it at once
   assign mem_req = (state == S_ISSUE);

   assign done  = done_ack | done_abort;
   assign rdata = done_ack ? mem_dout : 8'hFF;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // grant arbitration, completion detection and next state
   always_comb begin
      state_nxt  = state;
      gnt_ioc    = 1'b0;
      gnt_cpu    = 1'b0;
      gnt_tape   = 1'b0;
      done_ack   = 1'b0;
      done_abort = 1'b0;
      case (state)
         S_IDLE: begin
            if (ioc_full) begin
               gnt_ioc   = 1'b1;
               state_nxt = S_ISSUE;
            end else if (cpu_pend) begin
               gnt_cpu   = 1'b1;
               state_nxt = S_ISSUE;
            end else if (tape_pend && !rfsh_n) begin
               gnt_tape  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (mem_ack) begin
               done_ack  = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
               done_abort = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // WAIT-cycle counter, cleared while the request pulse is out
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                tmo_cnt <= '0;
      else if (state == S_ISSUE) tmo_cnt <= '0;
      else if (state == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
   end

   // request registers loaded at grant and held through the access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner    <= OWN_NONE;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else if (gnt_ioc) begin
         owner    <= OWN_IOC;
         mem_we   <= 1'b1;
         mem_addr <= ioc_addr;
         mem_din  <= ioc_data;
      end else if (gnt_cpu) begin
         owner    <= OWN_CPU;
         mem_we   <= cpu_we_q;
         mem_addr <= cpu_addr_q;
         mem_din  <= cpu_din_q;
      end else if (gnt_tape) begin
         owner    <= OWN_TAPE;
         mem_we   <= 1'b0;
         mem_addr <= tape_addr_q;
         mem_din  <= '0;
      end
   end

   // ioctl buffer: a strobe in the grant cycle refills it; a strobe while full is lost
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ioc_full  <= 1'b0;
         ioc_addr  <= '0;
         ioc_data  <= '0;
         ioctl_ovf <= 1'b0;
      end else if (ioctl_wr) begin
         if (!ioc_full || gnt_ioc) begin
            ioc_full <= 1'b1;
            ioc_addr <= ioctl_addr;
            ioc_data <= ioctl_data;
         end else begin
            ioctl_ovf <= 1'b1;
         end
      end else if (gnt_ioc) begin
         ioc_full <= 1'b0;
      end
   end

   // CPU request capture on the rising edge of rd|we; write wins when both are high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_prev   <= 1'b0;
         cpu_pend   <= 1'b0;
         cpu_we_q   <= 1'b0;
         cpu_addr_q <= '0;
         cpu_din_q  <= '0;
      end else begin
         cpu_prev <= cpu_act;
         if (cpu_rise) begin
            cpu_pend   <= 1'b1;
            cpu_we_q   <= cpu_we;
            cpu_addr_q <= cpu_addr;
            cpu_din_q  <= cpu_din;
         end else if (gnt_cpu) begin
            cpu_pend <= 1'b0;
         end
      end
   end

   // registered wait: covers the pending request and the CPU-owned access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cpu_wait <= 1'b0;
      else       cpu_wait <= cpu_pend | ((owner == OWN_CPU) && (state != S_IDLE));
   end

   // tape request capture at window open; dropped if the window closes before grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rfsh_prev   <= 1'b0;
         tape_pend   <= 1'b0;
         tape_addr_q <= '0;
      end else begin
         rfsh_prev <= rfsh_n;
         if (tape_fall && tape_rd && !tape_hit) begin
            tape_pend   <= 1'b1;
            tape_addr_q <= tape_addr;
         end else if (gnt_tape || rfsh_n || !tape_rd) begin
            tape_pend <= 1'b0;
         end
      end
   end

   // completion: CPU read data, tape data/valid pulse and cache update (ack only)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_dout   <= '0;
         tape_data  <= '0;
         tape_valid <= 1'b0;
         cache_vld  <= 1'b0;
         cache_addr <= '0;
      end else begin
         tape_valid <= done && (owner == OWN_TAPE);
         if (done && (owner == OWN_CPU) && !mem_we)
            cpu_dout <= rdata;
         if (done && (owner == OWN_TAPE)) begin
            tape_data <= rdata;
            if (done_ack) begin
               cache_vld  <= 1'b1;
               cache_addr <= mem_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a fixed-latency sram responder.
module tb_sram_port_arbiter;

   localparam int AW = 25;

   logic          clk = 1'b0;
   logic          reset;
   logic          ioctl_wr;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_data;
   logic          ioctl_ovf;
   logic          cpu_rd, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din, cpu_dout;
   logic          cpu_wait;
   logic          rfsh_n, tape_rd;
   logic [AW-1:0] tape_addr;
   logic [7:0]    tape_data;
   logic          tape_valid;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_ack;
   logic [7:0]    mem_dout;

   int vecs = 0;
   int errs = 0;
   int req_cnt = 0;
   int tv_cnt = 0;
   int r0, t0;
   logic       ack_en;
   logic [7:0] rd_val;

   sram_port_arbiter #(.AW(AW), .TIMEOUT(63), .TCACHE(1)) dut (
      .clk(clk), .reset(reset),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_ovf(ioctl_ovf),
      .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
      .rfsh_n(rfsh_n), .tape_rd(tape_rd), .tape_addr(tape_addr),
      .tape_data(tape_data), .tape_valid(tape_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_ack(mem_ack), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (mem_req === 1'b1)    req_cnt <= req_cnt + 1;
      if (tape_valid === 1'b1) tv_cnt  <= tv_cnt + 1;
   end

   // sram responder: ack 3 cycles after the request cycle (suppressed when ack_en=0)
   initial begin
      int busy;
      int cnt;
      busy = 0; cnt = 0;
      mem_ack = 1'b0; mem_dout = 8'h00;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (busy != 0) begin
            if (cnt == 0) begin
               mem_ack  = ack_en;
               mem_dout = rd_val;
               busy     = 0;
            end else begin
               cnt = cnt - 1;
            end
         end else if (mem_req === 1'b1) begin
            busy = 1;
            cnt  = 2;
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      ioctl_wr = 0; ioctl_addr = '0; ioctl_data = '0;
      cpu_rd = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
      rfsh_n = 1; tape_rd = 0; tape_addr = '0;
      ack_en = 1; rd_val = 8'h00;
      tick(2);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_bus", 32'({mem_we, mem_din}), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_cpu", 32'({cpu_wait, cpu_dout}), 0);
      chk("rst_tape", 32'({tape_valid, tape_data}), 0);
      chk("rst_ovf", 32'(ioctl_ovf), 0);
      reset = 1'b0;
      tick(2);

      // 1) single ioctl write
      r0 = req_cnt;
      ioctl_addr = 25'h000100; ioctl_data = 8'h5A; ioctl_wr = 1;
      tick(1); ioctl_wr = 0;
      chk("t1_req_not_yet", 32'(mem_req), 0);
      tick(1);
      chk("t1_req", 32'(mem_req), 1);
      chk("t1_we", 32'(mem_we), 1);
      chk("t1_addr", 32'(mem_addr), 32'h100);
      chk("t1_din", 32'(mem_din), 32'h5A);
      tick(6);
      chk("t1_req_count", 32'(req_cnt - r0), 1);
      chk("t1_ovf", 32'(ioctl_ovf), 0);

      // 2) CPU write in flight, two back-to-back ioctl strobes
      cpu_addr = 25'h000200; cpu_din = 8'h11; cpu_we = 1;
      tick(1);
      chk("t2_wait_lag", 32'(cpu_wait), 0);
      tick(1);
      chk("t2_cpu_req", 32'({mem_req, mem_we}), 32'h3);
      chk("t2_cpu_addr", 32'(mem_addr), 32'h200);
      chk("t2_cpu_wait", 32'(cpu_wait), 1);
      cpu_we = 0;
      tick(1);
      ioctl_addr = 25'h000300; ioctl_data = 8'h22; ioctl_wr = 1;
      tick(1);
      ioctl_addr = 25'h000301; ioctl_data = 8'h33;
      tick(1); ioctl_wr = 0;
      chk("t2_ovf", 32'(ioctl_ovf), 1);
      tick(2);
      chk("t2_ioc_req", 32'(mem_req), 1);
      chk("t2_ioc_addr", 32'(mem_addr), 32'h300);
      chk("t2_ioc_din", 32'(mem_din), 32'h22);
      chk("t2_wait_done", 32'(cpu_wait), 0);
      tick(6);

      // 3) ioctl buffer full and CPU read rising together
      rd_val = 8'hA7;
      ioctl_addr = 25'h000400; ioctl_data = 8'h44; ioctl_wr = 1;
      cpu_addr = 25'h014000; cpu_rd = 1;
      tick(1); ioctl_wr = 0;
      tick(1);
      chk("t3_ioc_first", 32'({mem_req, mem_we}), 32'h3);
      chk("t3_ioc_addr", 32'(mem_addr), 32'h400);
      chk("t3_wait_early", 32'(cpu_wait), 1);
      tick(4);
      chk("t3_dout_hold", 32'(cpu_dout), 0);
      chk("t3_wait_mid", 32'(cpu_wait), 1);
      tick(1);
      chk("t3_cpu_req", 32'({mem_req, mem_we}), 32'h2);
      chk("t3_cpu_addr", 32'(mem_addr), 32'h14000);
      tick(4);
      chk("t3_dout", 32'(cpu_dout), 32'hA7);
      chk("t3_wait_tail", 32'(cpu_wait), 1);
      tick(1);
      chk("t3_wait_drop", 32'(cpu_wait), 0);
      cpu_rd = 0;
      tick(2);

      // 4) tape fetch, cache hit, cache miss
      rd_val = 8'h3C;
      tape_addr = 25'h080000; tape_rd = 1; rfsh_n = 0;
      tick(2);
      chk("t4_req", 32'({mem_req, mem_we}), 32'h2);
      chk("t4_addr", 32'(mem_addr), 32'h80000);
      tick(1); rfsh_n = 1;
      tick(3);
      chk("t4_valid", 32'(tape_valid), 1);
      chk("t4_data", 32'(tape_data), 32'h3C);
      tick(1);
      chk("t4_valid_pulse", 32'(tape_valid), 0);
      tick(2);
      r0 = req_cnt; t0 = tv_cnt;
      rfsh_n = 0; tick(4); rfsh_n = 1; tick(3);
      chk("t4_hit_noreq", 32'(req_cnt - r0), 0);
      chk("t4_hit_novalid", 32'(tv_cnt - t0), 0);
      tape_addr = 25'h080001; rfsh_n = 0;
      tick(2);
      chk("t4_miss_req", 32'(mem_req), 1);
      chk("t4_miss_addr", 32'(mem_addr), 32'h80001);
      tick(1); rfsh_n = 1;
      tick(6); tape_rd = 0;

      // 5) tape window closes while CPU owns the port
      rd_val = 8'h5B; r0 = req_cnt; t0 = tv_cnt;
      cpu_addr = 25'h000500; cpu_rd = 1;
      tick(2);
      rfsh_n = 0; tape_addr = 25'h090000; tape_rd = 1;
      tick(2); rfsh_n = 1;
      tick(8);
      chk("t5_req_count", 32'(req_cnt - r0), 1);
      chk("t5_no_valid", 32'(tv_cnt - t0), 0);
      chk("t5_cpu_dout", 32'(cpu_dout), 32'h5B);
      cpu_rd = 0; tape_rd = 0;
      tick(2);

      // 6) no ack: abort after 63 WAIT cycles
      ack_en = 0;
      cpu_addr = 25'h000600; cpu_rd = 1;
      tick(2);
      chk("t6_req", 32'(mem_req), 1);
      chk("t6_addr", 32'(mem_addr), 32'h600);
      tick(63);
      chk("t6_dout_before", 32'(cpu_dout), 32'h5B);
      chk("t6_wait_before", 32'(cpu_wait), 1);
      tick(1);
      chk("t6_dout_ff", 32'(cpu_dout), 32'hFF);
      chk("t6_wait_tail", 32'(cpu_wait), 1);
      tick(1);
      chk("t6_wait_drop", 32'(cpu_wait), 0);
      chk("t6_no_rereq", 32'(mem_req), 0);
      cpu_rd = 0;
      tick(2);

      // reset in the middle of WAIT
      cpu_addr = 25'h000700; cpu_din = 8'h99; cpu_we = 1;
      tick(4);
      chk("rw_wait_pre", 32'(cpu_wait), 1);
      cpu_we = 0;
      #1 reset = 1'b1;
      #1;
      chk("rw_cpu", 32'({cpu_wait, cpu_dout}), 0);
      chk("rw_mem", 32'({mem_req, mem_we, mem_din}), 0);
      chk("rw_addr", 32'(mem_addr), 0);
      chk("rw_tape_ovf", 32'({ioctl_ovf, tape_valid, tape_data}), 0);
      tick(2);
      reset = 1'b0; ack_en = 1;
      tick(2);
      // cache was cleared by reset, so a previously cached address fetches again
      tape_addr = 25'h080001; tape_rd = 1; rfsh_n = 0;
      tick(2);
      chk("rw_cache_req", 32'(mem_req), 1);
      chk("rw_cache_addr", 32'(mem_addr), 32'h80001);
      tick(1); rfsh_n = 1; tape_rd = 0;
      tick(6);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
